// File: rtl/cga_text_serializer.sv
// CGA text-mode pixel serializer: latches one character cell per load and shifts out
// one IRGB index per pixel enable, applying blink, cursor and overscan border rules.
module cga_text_serializer #(
    parameter int BLINK_DIV_LOG2 = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pix_ce,
    input  logic       load,
    input  logic [7:0] font_bits,
    input  logic [7:0] attr,
    input  logic       cursor,
    input  logic       disp_en,
    input  logic [3:0] border,
    input  logic       blink_mode,
    input  logic       vsync,
    output logic [3:0] video,
    output logic       de_out
);

    localparam int CNT_W = BLINK_DIV_LOG2 + 2;

    logic [7:0]       shift_q, shift_d;
    logic [7:0]       attr_q, attr_d;
    logic             cursor_q, cursor_d;
    logic             de_q, de_d;
    logic [3:0]       video_q, video_d;
    logic             de_out_q, de_out_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             vsync_d_q, vsync_d_d;

    logic             cursor_phase;
    logic             char_phase;
    logic             pix_on;
    logic [3:0]       bg_color;

    assign cursor_phase = frame_cnt_q[BLINK_DIV_LOG2];
    assign char_phase   = frame_cnt_q[BLINK_DIV_LOG2+1];

    // Pixel colour uses the pre-update cell state, giving one pix_ce of latency.
    always_comb begin
        pix_on   = shift_q[7] & ~(blink_mode & attr_q[7] & ~char_phase);
        pix_on   = pix_on | (cursor_q & cursor_phase);
        bg_color = blink_mode ? {1'b0, attr_q[6:4]} : attr_q[7:4];
    end

    always_comb begin
        shift_d     = shift_q;
        attr_d      = attr_q;
        cursor_d    = cursor_q;
        de_d        = de_q;
        video_d     = video_q;
        de_out_d    = de_out_q;
        vsync_d_d   = vsync;
        frame_cnt_d = frame_cnt_q;

        if (vsync && !vsync_d_q) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end

        if (pix_ce) begin
            if (load) begin
                shift_d  = font_bits;
                attr_d   = attr;
                cursor_d = cursor;
                de_d     = disp_en;
            end else begin
                shift_d  = {shift_q[6:0], 1'b0};
            end
            video_d  = !de_q ? border : (pix_on ? attr_q[3:0] : bg_color);
            de_out_d = de_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q     <= '0;
            attr_q      <= '0;
            cursor_q    <= 1'b0;
            de_q        <= 1'b0;
            video_q     <= '0;
            de_out_q    <= 1'b0;
            frame_cnt_q <= '0;
            vsync_d_q   <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            attr_q      <= attr_d;
            cursor_q    <= cursor_d;
            de_q        <= de_d;
            video_q     <= video_d;
            de_out_q    <= de_out_d;
            frame_cnt_q <= frame_cnt_d;
            vsync_d_q   <= vsync_d_d;
        end
    end

    assign video  = video_q;
    assign de_out = de_out_q;

endmodule
